// File: rtl/m2s_dma_pkg.sv
// Shared types and width helpers for the multi-channel memory-to-stream DMA.
package m2s_dma_pkg;

   // Widest field sizes a descriptor can carry; instances use the low bits.
   localparam int unsigned DESC_ADDR_MAX = 64;
   localparam int unsigned DESC_LEN_MAX  = 64;
   localparam int unsigned DESC_CH_MAX   = 4;

   typedef struct packed {
      logic [DESC_ADDR_MAX-1:0] addr;
      logic [DESC_LEN_MAX-1:0]  len;
      logic [DESC_CH_MAX-1:0]   ch;
      logic                     irq_en;
   } desc_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } issue_state_e;

   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

   function automatic int unsigned burst_width(input int unsigned max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   function automatic int unsigned empty_width(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/m2s_dma_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata_o always presents the head entry.
module m2s_dma_sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/multi_channel_m2s_dma.sv
// Descriptor-driven memory-to-stream DMA: bursts reads into a credit-bounded
// response buffer and drains it as channel-tagged packets in descriptor order.
module multi_channel_m2s_dma
   import m2s_dma_pkg::*;
#(
   parameter  int unsigned DATA_W     = 512,
   parameter  int unsigned ADDR_W     = 48,
   parameter  int unsigned LEN_W      = 32,
   parameter  int unsigned NUM_CH     = 4,
   parameter  int unsigned MAX_BURST  = 4,
   parameter  int unsigned DESC_DEPTH = 8,
   parameter  int unsigned RSP_DEPTH  = 16,
   localparam int unsigned CH_W       = ch_width(NUM_CH),
   localparam int unsigned BURST_W    = burst_width(MAX_BURST),
   localparam int unsigned EMPTY_W    = empty_width(DATA_W)
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic               desc_valid,
   output logic               desc_ready,
   input  logic [ADDR_W-1:0]  desc_addr,
   input  logic [LEN_W-1:0]   desc_len,
   input  logic [CH_W-1:0]    desc_ch,
   input  logic               desc_irq_en,
   output logic [ADDR_W-1:0]  mem_read_address,
   output logic               mem_read_read,
   output logic [BURST_W-1:0] mem_read_burstcount,
   input  logic               mem_read_waitrequest,
   input  logic [DATA_W-1:0]  mem_read_readdata,
   input  logic               mem_read_readdatavalid,
   output logic [DATA_W-1:0]  m2s_st_source_data,
   output logic               m2s_st_source_valid,
   input  logic               m2s_st_source_ready,
   output logic               m2s_st_source_startofpacket,
   output logic               m2s_st_source_endofpacket,
   output logic [EMPTY_W-1:0] m2s_st_source_empty,
   output logic [CH_W-1:0]    m2s_st_source_channel,
   output logic [NUM_CH-1:0]  m2s_irq,
   input  logic [NUM_CH-1:0]  irq_clear,
   output logic               busy
);

   localparam int unsigned BYTES  = DATA_W / 8;
   localparam int unsigned SH     = $clog2(BYTES);
   localparam int unsigned DESC_W = $bits(desc_t);
   localparam int unsigned DCNT_W = $clog2(DESC_DEPTH + 1);
   localparam int unsigned RCNT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned CRED_W = $clog2(RSP_DEPTH + 1);

   // Beat count rounded up from a byte length.
   function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len);
      logic [LEN_W:0] sum;
      sum = {1'b0, len} + (LEN_W + 1)'(BYTES - 1);
      return LEN_W'(sum >> SH);
   endfunction

   desc_t               desc_in, desc_head, infl_head;
   logic                desc_push, desc_pop, desc_empty, desc_full;
   logic [DCNT_W-1:0]   desc_cnt, desc_cnt_next;
   logic                infl_full, infl_empty, infl_pop;
   logic [DCNT_W-1:0]   infl_cnt;
   logic                rsp_full, rsp_empty;
   logic [RCNT_W-1:0]   rsp_cnt;

   issue_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic                read_q, read_d;
   logic [BURST_W-1:0]  burst_q, burst_d;
   logic [BURST_W-1:0]  bc_c;
   logic                req_acc;

   logic [CRED_W-1:0]   credits_q, credits_d;
   logic [LEN_W-1:0]    beat_q, beat_d;
   logic [NUM_CH-1:0]   irq_q, irq_d, irq_set;
   logic                desc_ready_q, desc_ready_d;
   logic                st_valid, st_acc, last_c;
   logic [LEN_W-1:0]    head_len, head_beats;
   logic                sink_unused;

   assign desc_in = '{addr:   DESC_ADDR_MAX'(desc_addr),
                      len:    DESC_LEN_MAX'(desc_len),
                      ch:     DESC_CH_MAX'(desc_ch),
                      irq_en: desc_irq_en};

   // Zero-length descriptors are accepted but never enter the queue.
   assign desc_push = desc_valid && desc_ready_q && (desc_len != '0);

   m2s_dma_sync_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_desc_fifo (
      .clk(clk_clk), .rst(reset_reset),
      .push_i(desc_push), .wdata_i(desc_in), .pop_i(desc_pop),
      .rdata_o(desc_head), .full_o(desc_full), .empty_o(desc_empty), .count_o(desc_cnt)
   );

   m2s_dma_sync_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_infl_fifo (
      .clk(clk_clk), .rst(reset_reset),
      .push_i(desc_pop), .wdata_i(desc_head), .pop_i(infl_pop),
      .rdata_o(infl_head), .full_o(infl_full), .empty_o(infl_empty), .count_o(infl_cnt)
   );

   m2s_dma_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk(clk_clk), .rst(reset_reset),
      .push_i(mem_read_readdatavalid), .wdata_i(mem_read_readdata), .pop_i(st_acc),
      .rdata_o(m2s_st_source_data), .full_o(rsp_full), .empty_o(rsp_empty), .count_o(rsp_cnt)
   );

   assign bc_c    = (rem_q >= LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST) : BURST_W'(rem_q);
   assign req_acc = read_q && !mem_read_waitrequest;

   // Issue FSM state and request registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         read_q  <= 1'b0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         read_q  <= read_d;
         burst_q <= burst_d;
      end
   end

   // Issue FSM: load a descriptor, then emit credit-gated bursts held under stall.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      read_d   = read_q;
      burst_d  = burst_q;
      desc_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!desc_empty && !infl_full) begin
               desc_pop = 1'b1;
               addr_d   = desc_head.addr[ADDR_W-1:0];
               rem_d    = beats_of(desc_head.len[LEN_W-1:0]);
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (read_q) begin
               if (!mem_read_waitrequest) begin
                  read_d = 1'b0;
                  addr_d = addr_q + (ADDR_W'(burst_q) << SH);
                  rem_d  = rem_q - LEN_W'(burst_q);
                  if (rem_q == LEN_W'(burst_q)) state_d = ST_IDLE;
               end
            end else if (credits_q >= CRED_W'(bc_c)) begin
               read_d  = 1'b1;
               burst_d = bc_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign head_len   = infl_head.len[LEN_W-1:0];
   assign head_beats = beats_of(head_len);
   assign st_valid   = !rsp_empty;
   assign st_acc     = st_valid && m2s_st_source_ready;
   assign last_c     = (beat_q == head_beats - LEN_W'(1));
   assign infl_pop   = st_acc && last_c;
   assign irq_set    = (infl_pop && infl_head.irq_en)
                       ? (NUM_CH'(1) << infl_head.ch[CH_W-1:0]) : '0;
   assign desc_cnt_next = desc_cnt + DCNT_W'(desc_push) - DCNT_W'(desc_pop);

   // Next values for credits, drain beat index, sticky irqs and descriptor ready.
   always_comb begin
      credits_d    = credits_q + CRED_W'(st_acc) - (req_acc ? CRED_W'(burst_q) : '0);
      beat_d       = beat_q;
      if (st_acc) beat_d = last_c ? '0 : beat_q + LEN_W'(1);
      irq_d        = (irq_q & ~irq_clear) | irq_set;
      desc_ready_d = (desc_cnt_next != DCNT_W'(DESC_DEPTH));
   end

   // Drain-side and bookkeeping registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         credits_q    <= CRED_W'(RSP_DEPTH);
         beat_q       <= '0;
         irq_q        <= '0;
         desc_ready_q <= 1'b0;
      end else begin
         credits_q    <= credits_d;
         beat_q       <= beat_d;
         irq_q        <= irq_d;
         desc_ready_q <= desc_ready_d;
      end
   end

   assign desc_ready                  = desc_ready_q;
   assign mem_read_address            = addr_q;
   assign mem_read_read               = read_q;
   assign mem_read_burstcount         = burst_q;
   assign m2s_st_source_valid         = st_valid;
   assign m2s_st_source_startofpacket = st_valid && (beat_q == '0);
   assign m2s_st_source_endofpacket   = st_valid && last_c;
   assign m2s_st_source_empty         = m2s_st_source_endofpacket
                                        ? EMPTY_W'(LEN_W'(0) - head_len) : '0;
   assign m2s_st_source_channel       = st_valid ? infl_head.ch[CH_W-1:0] : '0;
   assign m2s_irq                     = irq_q;
   assign busy                        = !desc_empty || (state_q != ST_IDLE) || !infl_empty;

   assign sink_unused = ^{desc_head, infl_head, desc_full, infl_cnt, rsp_full, rsp_cnt};

endmodule

// File: tb/tb_multi_channel_m2s_dma.sv
// Directed bench for multi_channel_m2s_dma with a memory slave model and a stream scoreboard.
module tb_multi_channel_m2s_dma;

   localparam int unsigned DATA_W  = 512;
   localparam int unsigned ADDR_W  = 48;
   localparam int unsigned LEN_W   = 32;
   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned CH_W    = 2;
   localparam int unsigned BURST_W = 3;
   localparam int unsigned EMPTY_W = 6;

   logic               clk_clk, reset_reset;
   logic               desc_valid, desc_ready;
   logic [ADDR_W-1:0]  desc_addr;
   logic [LEN_W-1:0]   desc_len;
   logic [CH_W-1:0]    desc_ch;
   logic               desc_irq_en;
   logic [ADDR_W-1:0]  mem_read_address;
   logic               mem_read_read;
   logic [BURST_W-1:0] mem_read_burstcount;
   logic               mem_read_waitrequest;
   logic [DATA_W-1:0]  mem_read_readdata;
   logic               mem_read_readdatavalid;
   logic [DATA_W-1:0]  st_data;
   logic               st_valid, st_ready, st_sop, st_eop;
   logic [EMPTY_W-1:0] st_empty;
   logic [CH_W-1:0]    st_ch;
   logic [NUM_CH-1:0]  m2s_irq, irq_clear;
   logic               busy;

   multi_channel_m2s_dma #(
      .DATA_W(512), .ADDR_W(48), .LEN_W(32), .NUM_CH(4),
      .MAX_BURST(4), .DESC_DEPTH(8), .RSP_DEPTH(16)
   ) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len), .desc_ch(desc_ch), .desc_irq_en(desc_irq_en),
      .mem_read_address(mem_read_address), .mem_read_read(mem_read_read),
      .mem_read_burstcount(mem_read_burstcount), .mem_read_waitrequest(mem_read_waitrequest),
      .mem_read_readdata(mem_read_readdata), .mem_read_readdatavalid(mem_read_readdatavalid),
      .m2s_st_source_data(st_data), .m2s_st_source_valid(st_valid),
      .m2s_st_source_ready(st_ready), .m2s_st_source_startofpacket(st_sop),
      .m2s_st_source_endofpacket(st_eop), .m2s_st_source_empty(st_empty),
      .m2s_st_source_channel(st_ch), .m2s_irq(m2s_irq), .irq_clear(irq_clear), .busy(busy)
   );

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
      logic [CH_W-1:0]    ch;
   } beat_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [BURST_W-1:0] bc;
   } req_t;

   beat_t             exp_beats[$];
   req_t              exp_reqs[$];
   logic [ADDR_W-1:0] rd_q[$];

   int total = 0;
   int bad   = 0;
   int req_count = 0, req_beats = 0, beats_seen = 0;
   int stall_left = 0, stall_seen = 0;
   logic               in_stall = 1'b0;
   logic [ADDR_W-1:0]  held_addr;
   logic [BURST_W-1:0] held_bc;
   logic               prev_hold = 1'b0;
   beat_t              prev_beat;

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_W-1:0] mkdata(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = a[31:0] ^ (32'h9E37_0000 + 32'(i));
      return d;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory slave: one-cycle-later read data, programmable stall on the next request.
   always @(negedge clk_clk) begin
      if (reset_reset) begin
         rd_q.delete();
         mem_read_readdatavalid = 1'b0;
         mem_read_waitrequest   = 1'b0;
         stall_left             = 0;
         in_stall               = 1'b0;
      end else begin
         if (rd_q.size() > 0) begin
            mem_read_readdata      = mkdata(rd_q.pop_front());
            mem_read_readdatavalid = 1'b1;
         end else begin
            mem_read_readdatavalid = 1'b0;
         end
         if (mem_read_read) begin
            if (in_stall) begin
               check("stall addr hold", 64'(mem_read_address), 64'(held_addr));
               check("stall bc hold", 64'(mem_read_burstcount), 64'(held_bc));
            end
            if (stall_left > 0) begin
               if (!in_stall) begin
                  held_addr = mem_read_address;
                  held_bc   = mem_read_burstcount;
               end
               in_stall             = 1'b1;
               stall_left           = stall_left - 1;
               stall_seen           = stall_seen + 1;
               mem_read_waitrequest = 1'b1;
            end else begin
               req_t r;
               in_stall             = 1'b0;
               mem_read_waitrequest = 1'b0;
               req_count            = req_count + 1;
               req_beats            = req_beats + int'(mem_read_burstcount);
               if (exp_reqs.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected request: addr %0h bc %0d", mem_read_address, mem_read_burstcount);
               end else begin
                  r = exp_reqs.pop_front();
                  check("req addr", 64'(mem_read_address), 64'(r.addr));
                  check("req burstcount", 64'(mem_read_burstcount), 64'(r.bc));
               end
               for (int i = 0; i < int'(mem_read_burstcount); i++)
                  rd_q.push_back(mem_read_address + ADDR_W'(i * 64));
            end
         end else begin
            in_stall             = 1'b0;
            mem_read_waitrequest = 1'b0;
         end
      end
   end

   // Stream monitor: hold-stability under backpressure and scoreboard compare on acceptance.
   always @(negedge clk_clk) begin
      #1;
      if (reset_reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check_data("hold data", st_data, prev_beat.data);
            check("hold meta", 64'({st_valid, st_sop, st_eop, st_empty, st_ch}),
                  64'({1'b1, prev_beat.sop, prev_beat.eop, prev_beat.empty, prev_beat.ch}));
         end
         if (st_valid && st_ready) begin
            beats_seen++;
            if (exp_beats.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected beat: data %0h", st_data[31:0]);
            end else begin
               beat_t e;
               e = exp_beats.pop_front();
               check_data("beat data", st_data, e.data);
               check("beat sop", 64'(st_sop), 64'(e.sop));
               check("beat eop", 64'(st_eop), 64'(e.eop));
               check("beat empty", 64'(st_empty), 64'(e.empty));
               check("beat channel", 64'(st_ch), 64'(e.ch));
            end
         end
         prev_hold = st_valid && !st_ready;
         prev_beat = '{data: st_data, sop: st_sop, eop: st_eop, empty: st_empty, ch: st_ch};
      end
   end

   // Record expectations for one descriptor, then drive it until accepted.
   task automatic send_desc(input logic [ADDR_W-1:0] addr, input int len,
                            input logic [CH_W-1:0] ch, input logic irq);
      int nb, rem, bc, guard;
      logic [ADDR_W-1:0] a;
      if (len != 0) begin
         nb = (len + 63) / 64;
         for (int i = 0; i < nb; i++) begin
            beat_t b;
            b.data  = mkdata(addr + ADDR_W'(i * 64));
            b.sop   = (i == 0);
            b.eop   = (i == nb - 1);
            b.empty = (i == nb - 1) ? EMPTY_W'((64 - (len % 64)) % 64) : '0;
            b.ch    = ch;
            exp_beats.push_back(b);
         end
         a = addr; rem = nb;
         while (rem > 0) begin
            bc = (rem > 4) ? 4 : rem;
            exp_reqs.push_back('{addr: a, bc: BURST_W'(bc)});
            a   = a + ADDR_W'(bc * 64);
            rem = rem - bc;
         end
      end
      @(negedge clk_clk);
      desc_addr = addr; desc_len = LEN_W'(len); desc_ch = ch; desc_irq_en = irq;
      desc_valid = 1'b1;
      guard = 0;
      while (!desc_ready && guard < 1000) begin
         @(negedge clk_clk);
         guard++;
      end
      if (guard >= 1000) begin
         total++; bad++;
         $display("FAIL desc accept timeout: desc_ready stayed %0b", desc_ready);
      end
      @(negedge clk_clk);
      desc_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || exp_beats.size() != 0 || exp_reqs.size() != 0) && n < budget) begin
         @(negedge clk_clk);
         n++;
      end
      if (n >= budget) begin
         total++; bad++;
         $display("FAIL idle timeout: busy %0b beats left %0d reqs left %0d",
                  busy, exp_beats.size(), exp_reqs.size());
      end
   endtask

   initial begin
      int rc, rb, bs, guard;
      reset_reset = 1'b1;
      desc_valid = 1'b0; desc_addr = '0; desc_len = '0; desc_ch = '0; desc_irq_en = 1'b0;
      st_ready = 1'b1; irq_clear = '0;
      mem_read_readdata = '0;

      // Reset state and first ready edge.
      repeat (3) @(negedge clk_clk);
      check("reset desc_ready", 64'(desc_ready), 64'd0);
      check("reset read", 64'(mem_read_read), 64'd0);
      check("reset valid", 64'(st_valid), 64'd0);
      check("reset irq", 64'(m2s_irq), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      reset_reset = 1'b0;
      @(negedge clk_clk);
      check("ready after reset", 64'(desc_ready), 64'd1);

      // 200 bytes on ch2 with irq: one 4-beat burst, empty 56 on the last beat.
      rc = req_count; bs = beats_seen;
      send_desc(48'h1000, 200, 2'd2, 1'b1);
      wait_idle(500);
      check("len200 requests", 64'(req_count - rc), 64'd1);
      check("len200 beats", 64'(beats_seen - bs), 64'd4);
      check("len200 irq", 64'(m2s_irq), 64'b0100);
      irq_clear = 4'b0100;
      @(negedge clk_clk);
      irq_clear = '0;
      check("irq cleared", 64'(m2s_irq), 64'd0);

      // 640 bytes: bursts 4, 4, 2.
      rc = req_count; rb = req_beats; bs = beats_seen;
      send_desc(48'h20000, 640, 2'd0, 1'b0);
      wait_idle(500);
      check("len640 requests", 64'(req_count - rc), 64'd3);
      check("len640 req beats", 64'(req_beats - rb), 64'd10);
      check("len640 beats", 64'(beats_seen - bs), 64'd10);
      check("len640 no irq", 64'(m2s_irq), 64'd0);

      // Five-cycle stall on the first request.
      rc = req_count; stall_seen = 0; stall_left = 5;
      send_desc(48'h30000, 128, 2'd3, 1'b0);
      wait_idle(500);
      check("stall cycles", 64'(stall_seen), 64'd5);
      check("stall one request", 64'(req_count - rc), 64'd1);

      // Backpressure: only the 16 credited beats may be requested.
      st_ready = 1'b0; rb = req_beats; bs = beats_seen;
      send_desc(48'h40000, 512, 2'd1, 1'b0);
      send_desc(48'h41000, 512, 2'd1, 1'b0);
      send_desc(48'h42000, 512, 2'd1, 1'b0);
      repeat (60) @(negedge clk_clk);
      check("bp requested beats", 64'(req_beats - rb), 64'd16);
      check("bp no beats out", 64'(beats_seen - bs), 64'd0);
      check("bp busy", 64'(busy), 64'd1);
      st_ready = 1'b1;
      wait_idle(1000);
      check("bp total beats", 64'(beats_seen - bs), 64'd24);
      check("bp total requested", 64'(req_beats - rb), 64'd24);

      // Completion on ch1 coinciding with irq_clear[1]: set wins.
      st_ready = 1'b0;
      send_desc(48'h50000, 64, 2'd1, 1'b1);
      guard = 0;
      while (!st_valid && guard < 200) begin
         @(negedge clk_clk);
         guard++;
      end
      check("single beat sop/eop", 64'({st_valid, st_sop, st_eop}), 64'b111);
      st_ready = 1'b1; irq_clear = 4'b0010;
      @(negedge clk_clk);
      check("set wins over clear", 64'(m2s_irq), 64'b0010);
      @(negedge clk_clk);
      irq_clear = '0;
      check("clear alone", 64'(m2s_irq), 64'd0);

      // Zero-length descriptor: no reads, no irq, busy low.
      rc = req_count;
      send_desc(48'h51000, 0, 2'd2, 1'b1);
      repeat (10) @(negedge clk_clk);
      check("len0 no requests", 64'(req_count - rc), 64'd0);
      check("len0 busy", 64'(busy), 64'd0);
      check("len0 no irq", 64'(m2s_irq), 64'd0);

      // Reset in the middle of a packet.
      st_ready = 1'b1; bs = beats_seen;
      send_desc(48'h60000, 512, 2'd0, 1'b1);
      guard = 0;
      while (beats_seen == bs && guard < 200) begin
         @(negedge clk_clk);
         guard++;
      end
      check("midpkt started", 64'(beats_seen > bs), 64'd1);
      reset_reset = 1'b1;
      #1;
      check("rst desc_ready", 64'(desc_ready), 64'd0);
      check("rst read", 64'(mem_read_read), 64'd0);
      check("rst valid", 64'(st_valid), 64'd0);
      check("rst sop", 64'(st_sop), 64'd0);
      check("rst eop", 64'(st_eop), 64'd0);
      check("rst empty", 64'(st_empty), 64'd0);
      check("rst channel", 64'(st_ch), 64'd0);
      check("rst irq", 64'(m2s_irq), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      exp_beats.delete();
      exp_reqs.delete();
      repeat (3) @(negedge clk_clk);
      reset_reset = 1'b0;
      @(negedge clk_clk);
      check("ready after mid reset", 64'(desc_ready), 64'd1);
      bs = beats_seen;
      send_desc(48'h70000, 100, 2'd3, 1'b1);
      wait_idle(500);
      check("post reset beats", 64'(beats_seen - bs), 64'd2);
      check("post reset irq", 64'(m2s_irq), 64'b1000);

      check("leftover beats", 64'(exp_beats.size()), 64'd0);
      check("leftover reqs", 64'(exp_reqs.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
